// File: rtl/apb_slave_if.sv
// APB completer bus bundle: the signals between the APB master and the apb_slave register file.
// Latency: none (wires only).
// Backpressure: the completer stretches the access phase by holding pready low.
// Ports (slave view): psel/penable/pwrite/padd/pwdata in; prdata/pready/pslverr out.
interface apb_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] padd;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, padd, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, padd, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave.sv
// APB completer with a DEPTH-entry register file, WAIT_CYCLES wait states and pslverr for out-of-range addresses.
// Latency: pready rises WAIT_CYCLES access cycles after the setup edge (first access cycle when WAIT_CYCLES=0).
// Backpressure: pready held low while the wait counter runs; psel dropped before completion aborts the transfer.
// Ports: clk (rising edge), rst (async active-low), bus (apb_slave_if.slave: psel/penable/pwrite/padd/pwdata in,
//        prdata/pready/pslverr out; all outputs registered).
module apb_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  apb_slave_if.slave   bus
);

  // DEPTH is assumed to be <= 2**ADDR_WIDTH, so the low IDX_W address bits index the file.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable and nothing ever compares out of range.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]    WAIT_W  = CNT_W'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                state_q,   state_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                  write_q,   write_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  pready_q,  pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdat;

  // Response launch: the edge that raises pready also loads prdata/pslverr.
  logic                  resp_fire;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic                  resp_write;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    prdata_d   = prdata_q;
    mem_we     = 1'b0;
    mem_idx    = addr_q[IDX_W-1:0];
    mem_wdat   = wdata_q;
    resp_fire  = 1'b0;
    resp_addr  = addr_q;
    resp_write = write_q;

    case (state_q)
      S_IDLE: begin
        // penable without a preceding setup, or anything with psel low, is ignored here.
        if (bus.psel && !bus.penable) begin
          state_d = S_ACCESS;
          addr_d  = bus.padd;
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          cnt_d   = WAIT_W;
          // Zero-wait: respond on the setup edge using the live (just captured) request.
          if (WAIT_CYCLES == 0) begin
            resp_fire  = 1'b1;
            resp_addr  = bus.padd;
            resp_write = bus.pwrite;
          end
        end
      end

      S_ACCESS: begin
        if (!bus.psel) begin
          // Abort: master walked away before completion, no register update.
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (bus.penable) begin
          if (pready_q) begin
            mem_we    = write_q && in_range(addr_q);
            state_d   = S_IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              resp_fire = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (resp_fire) begin
      pready_d = 1'b1;
      if (resp_write) begin
        pslverr_d = !in_range(resp_addr);
      end else if (in_range(resp_addr)) begin
        prdata_d  = mem_q[resp_addr[IDX_W-1:0]];
        pslverr_d = 1'b0;
      end else begin
        prdata_d  = '0;
        pslverr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Register file is cleared on reset so a reset mid-transfer leaves no partial write behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= mem_wdat;
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: three instances (W0/D256, W2/D256, W3/D16) driven by an APB master task.
// Expected values come from a transaction-level model: a plain byte array per instance plus the
// rules "access cycles = WAIT+1", "pslverr = addr >= DEPTH", "read data = in range ? mem : 0".
module tb_apb_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       m_psel   [3];
  logic       m_pen    [3];
  logic       m_pwrite [3];
  logic [7:0] m_padd   [3];
  logic [7:0] m_pwdata [3];
  logic [7:0] s_prdata [3];
  logic [2:0] s_pready;
  logic [2:0] s_pslverr;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    apb_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
    assign bus.psel     = m_psel[g];
    assign bus.penable  = m_pen[g];
    assign bus.pwrite   = m_pwrite[g];
    assign bus.padd     = m_padd[g];
    assign bus.pwdata   = m_pwdata[g];
    assign s_prdata[g]  = bus.prdata;
    assign s_pready[g]  = bus.pready;
    assign s_pslverr[g] = bus.pslverr;
    apb_slave #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .DEPTH      ((g == 2) ? 16 : 256),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  int         checks   = 0;
  int         failures = 0;
  int         mdepth [3] = '{256, 256, 16};
  int         mwait  [3] = '{0, 2, 3};
  logic [7:0] mmem   [3][256];
  logic [7:0] mlast  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      mlast[d] = 8'h00;
      for (int a = 0; a < 256; a++) mmem[d][a] = 8'h00;
    end
  endtask

  // Called just after a rising edge; returns just after the completion edge with psel low,
  // so a following call starts its setup with no idle cycle in between.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input string tag, output logic [7:0] rd);
    int   n;
    bit   got;
    bit   oor;
    logic [7:0] exp_rd;
    oor    = (int'(a) >= mdepth[d]);
    exp_rd = wr ? mlast[d] : (oor ? 8'h00 : mmem[d][a]);
    m_psel[d] = 1'b1; m_pen[d] = 1'b0; m_pwrite[d] = wr; m_padd[d] = a; m_pwdata[d] = wd;
    @(posedge clk); #1;
    // Address/data wander during access; the captured values must be used.
    m_pen[d] = 1'b1; m_padd[d] = ~a; m_pwdata[d] = ~wd;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (s_pready[d]) got = 1'b1;
    end
    check({tag, "_ready"}, 32'(got), 32'd1);
    check({tag, "_acc_cycles"}, n, mwait[d] + 1);
    check({tag, "_prdata"}, 32'(s_prdata[d]), 32'(exp_rd));
    check({tag, "_pslverr"}, 32'(s_pslverr[d]), 32'(oor));
    rd = s_prdata[d];
    @(posedge clk); #1;
    m_psel[d] = 1'b0; m_pen[d] = 1'b0;
    check({tag, "_ready_drop"}, 32'(s_pready[d]), 32'd0);
    mlast[d] = exp_rd;
    if (wr && !oor) mmem[d][a] = wd;
  endtask

  initial begin
    logic [7:0] rd;
    for (int d = 0; d < 3; d++) begin
      m_psel[d] = 1'b0; m_pen[d] = 1'b0; m_pwrite[d] = 1'b0; m_padd[d] = '0; m_pwdata[d] = '0;
    end
    model_clear();
    #1;
    for (int d = 0; d < 3; d++) begin
      check("reset_pready", 32'(s_pready[d]), 32'd0);
      check("reset_pslverr", 32'(s_pslverr[d]), 32'd0);
      check("reset_prdata", 32'(s_prdata[d]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write then read.
    xfer(0, 1'b1, 8'hab, 8'hcd, "t1_wr", rd);
    xfer(0, 1'b0, 8'hab, 8'h00, "t1_rd", rd);
    check("t1_rd_value", 32'(rd), 32'h cd);

    // Two wait states.
    xfer(1, 1'b1, 8'h10, 8'h5a, "t2_wr", rd);
    xfer(1, 1'b0, 8'h10, 8'h00, "t2_rd", rd);
    check("t2_rd_value", 32'(rd), 32'h5a);

    // DEPTH=16: out-of-range write/read; 0x20 aliases onto index 0 in the low bits.
    xfer(2, 1'b1, 8'h03, 8'haa, "t3_wr_in", rd);
    xfer(2, 1'b0, 8'h03, 8'h00, "t3_rd_in", rd);
    check("t3_rd_in_value", 32'(rd), 32'haa);
    xfer(2, 1'b1, 8'h20, 8'hff, "t3_wr_oor", rd);
    xfer(2, 1'b0, 8'h20, 8'h00, "t3_rd_oor", rd);
    check("t3_rd_oor_value", 32'(rd), 32'h00);
    xfer(2, 1'b0, 8'h00, 8'h00, "t3_rd_0", rd);
    check("t3_rd_0_value", 32'(rd), 32'h00);
    xfer(2, 1'b0, 8'h0f, 8'h00, "t3_rd_15", rd);

    // Back-to-back writes then reads.
    xfer(0, 1'b1, 8'h01, 8'h11, "t4_wr1", rd);
    xfer(0, 1'b1, 8'h02, 8'h22, "t4_wr2", rd);
    xfer(0, 1'b1, 8'h03, 8'h33, "t4_wr3", rd);
    xfer(0, 1'b0, 8'h01, 8'h00, "t4_rd1", rd);
    check("t4_rd1_value", 32'(rd), 32'h11);
    xfer(0, 1'b0, 8'h02, 8'h00, "t4_rd2", rd);
    check("t4_rd2_value", 32'(rd), 32'h22);
    xfer(0, 1'b0, 8'h03, 8'h00, "t4_rd3", rd);
    check("t4_rd3_value", 32'(rd), 32'h33);

    // Abort after one access cycle at WAIT_CYCLES=3.
    m_psel[2] = 1'b1; m_pen[2] = 1'b0; m_pwrite[2] = 1'b1; m_padd[2] = 8'h05; m_pwdata[2] = 8'h77;
    @(posedge clk); #1;
    m_pen[2] = 1'b1;
    @(negedge clk);
    check("t5_acc1_pready", 32'(s_pready[2]), 32'd0);
    @(posedge clk); #1;
    m_psel[2] = 1'b0; m_pen[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_abort_pready", 32'(s_pready[2]), 32'd0);
      check("t5_abort_pslverr", 32'(s_pslverr[2]), 32'd0);
    end
    @(posedge clk); #1;
    xfer(2, 1'b0, 8'h05, 8'h00, "t5_rd", rd);
    check("t5_rd_value", 32'(rd), 32'h00);

    // penable without setup in IDLE is ignored.
    m_psel[0] = 1'b1; m_pen[0] = 1'b1; m_pwrite[0] = 1'b0; m_padd[0] = 8'hab;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ign_pready", 32'(s_pready[0]), 32'd0);
    end
    @(posedge clk); #1;
    m_psel[0] = 1'b0; m_pen[0] = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 30; k++) begin
        bit         wr;
        logic [7:0] a;
        wr = 1'($urandom);
        if (d == 0) a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(240, 255));
        else        a = 8'($urandom_range(0, 31));
        xfer(d, wr, a, 8'($urandom), "rand", rd);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

    // Reset in the access phase of a write.
    xfer(0, 1'b1, 8'h07, 8'h99, "t6_wr7", rd);
    xfer(0, 1'b0, 8'h07, 8'h00, "t6_rd7_pre", rd);
    check("t6_rd7_pre_value", 32'(rd), 32'h99);
    m_psel[0] = 1'b1; m_pen[0] = 1'b0; m_pwrite[0] = 1'b1; m_padd[0] = 8'h08; m_pwdata[0] = 8'h44;
    @(posedge clk); #1;
    m_pen[0] = 1'b1;
    #2;
    check("t6_pre_rst_pready", 32'(s_pready[0]), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_pready", 32'(s_pready[0]), 32'd0);
    check("t6_rst_pslverr", 32'(s_pslverr[0]), 32'd0);
    check("t6_rst_prdata", 32'(s_prdata[0]), 32'd0);
    m_psel[0] = 1'b0; m_pen[0] = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 8'h07, 8'h00, "t6_rd7", rd);
    check("t6_rd7_value", 32'(rd), 32'h00);
    xfer(0, 1'b0, 8'h08, 8'h00, "t6_rd8", rd);
    check("t6_rd8_value", 32'(rd), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_slave.md
Name: apb_slave

Overview:
- APB completer (slave) that terminates transfers from the team's APB master.
- Contains a DEPTH-entry register file, inserts a parameterised number of wait states, and flags out-of-range addresses with pslverr.
- Pairs directly with APB_master: psel/penable/pwrite/padd/pwdata in, prdata/pready out.

Parameters:
- ADDR_WIDTH, 8, width of padd.
- DATA_WIDTH, 8, width of pwdata/prdata and of each register.
- DEPTH, 256, number of registers; valid addresses 0..DEPTH-1.
- WAIT_CYCLES, 0, access-phase cycles with pready low before completion (0 = zero-wait).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- psel  input  1  slave select from master.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- padd  input  ADDR_WIDTH  transfer address.
- pwdata  input  DATA_WIDTH  write data.
- prdata  output  DATA_WIDTH  read data, valid while pready=1 on a read.
- pready  output  1  transfer completion, registered.
- pslverr  output  1  error response, valid only while pready=1.

Behaviour:
- Reset (rst=0, asynchronous): prdata=0, pready=0, pslverr=0, all registers=0, wait counter=0, state=IDLE.
- States:
  - IDLE: no transfer in progress.
  - ACCESS: transfer accepted, waiting to complete.
- Setup edge: the rising edge where psel=1 and penable=0 are sampled.
  - Capture padd, pwrite and pwdata internally.
  - Load counter with WAIT_CYCLES.
  - Move to ACCESS.
  - If WAIT_CYCLES=0, drive pready<=1 on this same edge, so completion occurs in the first access cycle.
- ACCESS, counter>0: on each edge with psel=1 and penable=1, decrement the counter.
  - When the counter reaches 1 and decrements to 0, drive pready<=1.
  - Result: pready is low for exactly WAIT_CYCLES access cycles, then high for one cycle.
- The pready<=1 edge also drives the response:
  - Read, in range: prdata<=reg[captured addr], pslverr<=0.
  - Read, out of range (addr>=DEPTH): prdata<=0, pslverr<=1.
  - Write: pslverr<=(addr>=DEPTH); prdata unchanged.
- Completion edge: the edge where psel=1, penable=1 and pready=1 are sampled.
  - Write, in range: reg[captured addr]<=captured pwdata.
  - Write, out of range: register file unchanged.
  - pready<=0, pslverr<=0, state<=IDLE.
- Back-to-back transfers: the master drives the next setup in the cycle after completion, and it is accepted from IDLE normally.
- No bubble is required beyond APB's mandatory setup cycle.
- prdata holds its last read value until the next read response or reset.
- Abort: psel=0 sampled in ACCESS before completion.
  - Return to IDLE with no register write; pready=0, pslverr=0.
- Ignored conditions:
  - penable=1 sampled in IDLE without a preceding setup: no state change.
  - Any input sampled while psel=0 in IDLE: no effect.
- Address/data changes during ACCESS are ignored; the captured values are used.
- Reset asserted mid-transfer: immediate return to reset values, register file cleared, and no partial write.
- Out-of-range check: padd compared as unsigned against DEPTH. When DEPTH=2^ADDR_WIDTH, pslverr is never set.

Test Plan:
1. WAIT_CYCLES=0, DEPTH=256: write 8'hcd to 8'hab, then read 8'hab -> write completes in 1 access cycle; read returns prdata=8'hcd with pready=1 in the first access cycle; pslverr=0.
2. WAIT_CYCLES=2: read of 8'h10 after writing 8'h5a -> pready low for 2 access cycles, high in the 3rd; prdata=8'h5a; total transfer 4 cycles including setup.
3. DEPTH=16: write 8'hff to address 8'h20, then read 8'h20 -> pslverr=1 with pready on both transfers; read prdata=0; registers 0..15 unchanged (read 8'h00 returns 0).
4. Back-to-back writes to addresses 1, 2, 3 (data 8'h11, 8'h22, 8'h33) with no idle cycles between, then read all three -> data returned in order; each transfer takes 2 cycles at WAIT_CYCLES=0.
5. WAIT_CYCLES=3: drop psel after 1 access cycle of a write of 8'h77 to 8'h05 -> no pready pulse; subsequent read of 8'h05 returns 0.
6. Pull rst low during the access phase of a write to 8'h08, after writing 8'h99 to 8'h07 -> outputs 0 immediately (asynchronous); after release, reads of 8'h07 and 8'h08 both return 0.
